// File: rtl/jt10_adpcma_enc_pkg.sv
// jt10_adpcma_enc_pkg: shared step/adjust tables and encoder FSM states for the ADPCM-A capture path
package jt10_adpcma_enc_pkg;
  localparam int IDX_MAX = 48;
  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_Q2, S_Q1, S_Q0, S_UPD} state_t;
  localparam logic [11:0] STEP [49] = '{
    16, 17, 19, 21, 23, 25, 28, 31, 34, 37,
    41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
    107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
    279, 307, 337, 371, 408, 449, 494, 544, 598, 658,
    724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  localparam logic signed [4:0] ADJ [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd5, 5'sd7, 5'sd9};
endpackage

// File: rtl/jt10_adpcma_enc_if.sv
// jt10_adpcma_enc_if: PCM input, nibble output and byte valid/ready port of the encoder
interface jt10_adpcma_enc_if;
  logic in_valid;
  logic signed [15:0] pcm_in;
  logic [3:0] nib;
  logic nib_valid;
  logic [7:0] byte_data;
  logic byte_valid;
  logic byte_ready;
  modport master (output in_valid, pcm_in, byte_ready, input nib, nib_valid, byte_data, byte_valid);
  modport slave (input in_valid, pcm_in, byte_ready, output nib, nib_valid, byte_data, byte_valid);
endinterface

// File: rtl/jt10_adpcma_enc_lut.sv
// jt10_adpcma_enc_lut: step-index to quantiser step size ROM
module jt10_adpcma_enc_lut
  import jt10_adpcma_enc_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [11:0] o_step
);
  assign o_step = STEP[i_idx];
endmodule

// File: rtl/jt10_adpcma_enc.sv
// jt10_adpcma_enc: decimate-by-3 PCM, ADPCM-A encode to nibbles and pack them into bytes
module jt10_adpcma_enc
  import jt10_adpcma_enc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_cen,
  input  logic i_clr,
  jt10_adpcma_enc_if.slave io_bus,
  output logic o_busy,
  output logic o_ovf
);
  state_t r_state, w_state_n;
  logic [1:0] r_cnt;
  logic signed [17:0] r_sum, w_sum;
  logic [11:0] r_x, r_pred, w_x12, w_step, w_cmp, w_delta, w_pred_n;
  logic [5:0] r_idx, w_idx_n;
  logic signed [7:0] w_idx_sum;
  logic signed [12:0] w_d;
  logic [12:0] r_m, w_abs;
  logic [2:0] r_b;
  logic [3:0] r_nib, r_hi, w_nib;
  logic [7:0] r_bd;
  logic r_sign, r_nv, r_half, r_ovf, r_bv, w_dstb, w_upd, w_ge, w_acc, w_load;

  jt10_adpcma_enc_lut u_lut (.i_idx(r_idx), .o_step(w_step));

  // dec = sum*(1/4+1/16+1/64+1/256) with floor shifts, then keep bits [15:4]
  assign w_sum = r_sum + 18'(io_bus.pcm_in);
  assign w_x12 = 12'(((w_sum >>> 2) + (w_sum >>> 4) + (w_sum >>> 6) + (w_sum >>> 8)) >>> 4);
  assign w_dstb = i_cen & io_bus.in_valid & (r_cnt == 2'd2);
  assign w_d = $signed({r_x[11], r_x}) - $signed({r_pred[11], r_pred});
  assign w_abs = w_d[12] ? -w_d : w_d;
  assign w_cmp = (r_state == S_Q2) ? w_step : (r_state == S_Q1) ? w_step >> 1 : w_step >> 2;
  assign w_ge = r_m >= {1'b0, w_cmp};
  assign w_nib = {r_sign, r_b};
  assign w_delta = 12'(({r_b, 1'b1} * 15'(w_step)) >> 3);
  assign w_pred_n = r_sign ? r_pred - w_delta : r_pred + w_delta;
  assign w_idx_sum = $signed({2'b0, r_idx}) + 8'(ADJ[r_b]);
  assign w_idx_n = (w_idx_sum < 0) ? 6'd0 : (w_idx_sum > 8'(IDX_MAX)) ? 6'(IDX_MAX) : w_idx_sum[5:0];
  assign w_acc = r_bv & io_bus.byte_ready;
  assign w_load = w_upd & r_half & ~i_clr & (~r_bv | w_acc);

  always_ff @(posedge clk)
    r_state <= (rst || i_clr) ? S_IDLE : w_state_n;

  always_comb begin
    w_state_n = r_state;
    o_busy = r_state != S_IDLE;
    w_upd = i_cen && r_state == S_UPD;
    if (i_cen)
      w_state_n = (r_state == S_IDLE) ? (w_dstb ? S_DIFF : S_IDLE) :
                  (r_state == S_UPD) ? S_IDLE : state_t'(r_state + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_sum <= '0;
      r_x <= '0;
      r_pred <= '0;
      r_idx <= '0;
      r_m <= '0;
      r_b <= '0;
      r_sign <= 1'b0;
      r_nib <= '0;
      r_nv <= 1'b0;
      r_half <= 1'b0;
      r_hi <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_nv <= w_upd;
      if (i_cen && io_bus.in_valid) begin
        r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
        r_sum <= (r_cnt == 2'd2) ? '0 : w_sum;
      end
      if (w_dstb && o_busy) r_ovf <= 1'b1;
      if (w_dstb && !o_busy) r_x <= w_x12;
      if (i_cen && r_state == S_DIFF) begin
        r_sign <= w_d[12];
        r_m <= w_abs;
        r_b <= '0;
      end
      if (i_cen && (r_state == S_Q2 || r_state == S_Q1 || r_state == S_Q0)) begin
        r_b <= {r_b[1:0], w_ge};
        if (w_ge) r_m <= r_m - {1'b0, w_cmp};
      end
      if (w_upd) begin
        r_pred <= w_pred_n;
        r_idx <= w_idx_n;
        r_nib <= w_nib;
        r_half <= ~r_half;
        r_hi <= r_half ? r_hi : w_nib;
        if (r_half && r_bv && !w_acc) r_ovf <= 1'b1;
      end
    end
  end

  // a held byte survives clr so the consumer can still take it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bv <= 1'b0;
      r_bd <= '0;
    end else begin
      r_bv <= w_load | (r_bv & ~w_acc);
      if (w_load) r_bd <= {r_hi, w_nib};
    end
  end

  assign io_bus.nib = r_nib;
  assign io_bus.nib_valid = r_nv;
  assign io_bus.byte_data = r_bd;
  assign io_bus.byte_valid = r_bv;
  assign o_ovf = r_ovf;
endmodule

// File: tb/tb_jt10_adpcma_enc.sv
// tb_jt10_adpcma_enc: directed stimulus with a behavioural ADPCM-A encoder/packer reference
module tb_jt10_adpcma_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic clr = 1'b0;
  logic busy, ovf;
  logic signed [15:0] pcm = 16'sd0;
  jt10_adpcma_enc_if bus();

  jt10_adpcma_enc dut (.clk(clk), .rst(rst), .i_cen(cen), .i_clr(clr), .io_bus(bus), .o_busy(busy), .o_ovf(ovf));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int step_t [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
                      107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
                      494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  int adj_t [8] = '{-1, -1, -1, -1, 2, 5, 7, 9};
  int m_sum, m_cnt, m_left, m_pred, m_idx, m_pend, m_hi, m_bd, m_nib;
  bit m_half, m_bv, m_ovf, m_nv;
  int got[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset(input bit full);
    m_sum = 0; m_cnt = 0; m_left = 0; m_pred = 0; m_idx = 0; m_pend = 0; m_hi = 0; m_nib = 0;
    m_half = 0; m_ovf = 0; m_nv = 0;
    if (full) begin m_bv = 0; m_bd = 0; end
  endtask

  function automatic int enc(input int x);
    int d, m, st, mag, delta;
    bit sgn;
    d = x - m_pred;
    sgn = d < 0;
    m = sgn ? -d : d;
    st = step_t[m_idx];
    mag = 0;
    if (m >= st) begin mag += 4; m -= st; end
    if (m >= st / 2) begin mag += 2; m -= st / 2; end
    if (m >= st / 4) mag += 1;
    delta = ((2 * mag + 1) * st) / 8;
    m_pred = m_pred + (sgn ? -delta : delta);
    m_pred = ((m_pred + 2048) & 4095) - 2048;
    m_idx = m_idx + adj_t[mag];
    m_idx = (m_idx < 0) ? 0 : (m_idx > 48) ? 48 : m_idx;
    return (sgn ? 8 : 0) + mag;
  endfunction

  task automatic clk_step(input bit c, input bit v);
    bit acc, busy_now, emit;
    int s, x;
    cen = c; bus.in_valid = v; bus.pcm_in = pcm;
    @(posedge clk);
    emit = 0;
    acc = m_bv && bus.byte_ready;
    if (rst) mreset(1);
    else if (clr) begin
      mreset(0);
      if (acc) m_bv = 0;
    end else begin
      m_nv = 0;
      if (c) begin
        busy_now = m_left > 0;
        if (busy_now) begin m_left--; emit = m_left == 0; end
        if (emit) begin
          m_nib = m_pend; m_nv = 1;
          if (!m_half) begin m_hi = m_pend; m_half = 1; end
          else begin
            m_half = 0;
            if (m_bv && !acc) m_ovf = 1;
            else begin m_bd = m_hi * 16 + m_pend; m_bv = 1; acc = 0; end
          end
        end
        if (v) begin
          m_sum += int'(pcm);
          if (m_cnt == 2) begin
            s = m_sum;
            x = ((s >>> 2) + (s >>> 4) + (s >>> 6) + (s >>> 8)) >>> 4;
            m_sum = 0; m_cnt = 0;
            if (busy_now) m_ovf = 1;
            else begin m_pend = enc(x); m_left = 5; end
          end else m_cnt++;
        end
      end
      if (acc) m_bv = 0;
    end
    #1;
    if (bus.nib_valid) got.push_back(int'(bus.nib));
    check("nib_valid", 16'(bus.nib_valid), 16'(m_nv));
    check("nib", 16'(bus.nib), 16'(m_nib));
    check("busy", 16'(busy), 16'(m_left > 0));
    check("byte_valid", 16'(bus.byte_valid), 16'(m_bv));
    check("byte_data", 16'(bus.byte_data), 16'(m_bd));
    check("ovf", 16'(ovf), 16'(m_ovf));
  endtask

  task automatic tick(input bit v);
    clk_step(1'b1, v);
    clk_step(1'b0, 1'b0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    clk_step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    clk_step(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.pcm_in = 16'sd0;
    bus.byte_ready = 1'b0;
    mreset(1);
    clk_step(1'b0, 1'b0);
    clk_step(1'b0, 1'b0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_bv", 16'(bus.byte_valid), 16'h0);
    check("rst_ovf", 16'(ovf), 16'h0);
    rst = 1'b0;

    bus.byte_ready = 1'b1;
    pcm = 16'sd0;
    got.delete();
    for (int t = 0; t < 48; t++) tick(t % 2 == 0);
    check("zero_count", 16'(got.size() >= 4), 16'h1);
    if (got.size() >= 4) begin
      check("zero_n0", 16'(got[0]), 16'h0);
      check("zero_n1", 16'(got[1]), 16'h8);
      check("zero_n2", 16'(got[2]), 16'h0);
      check("zero_n3", 16'(got[3]), 16'h8);
    end
    check("zero_byte", 16'(bus.byte_data), 16'h08);

    do_rst();
    got.delete();
    pcm = 16'sh7FF0;
    for (int t = 0; t < 42; t++) tick(t % 2 == 0);
    check("fs_count", 16'(got.size() >= 6), 16'h1);
    if (got.size() >= 6) begin
      check("fs_n0", 16'(got[0]), 16'h7);
      check("fs_n1", 16'(got[1]), 16'h7);
      check("fs_n4", 16'(got[4]), 16'h7);
      check("fs_n5", 16'(got[5]), 16'h1);
    end
    check("fs_byte", 16'(bus.byte_data), 16'h71);

    bus.byte_ready = 1'b0;
    for (int t = 42; t < 55; t++) tick(t % 2 == 0);
    check("pre_rst_bv", 16'(bus.byte_valid), 16'h1);
    check("pre_rst_busy", 16'(busy), 16'h1);
    do_rst();
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_nib", 16'(bus.nib), 16'h0);
    check("mid_rst_bv", 16'(bus.byte_valid), 16'h0);
    check("mid_rst_ovf", 16'(ovf), 16'h0);
    got.delete();
    bus.byte_ready = 1'b1;
    pcm = 16'sd0;
    for (int t = 0; t < 12; t++) tick(t % 2 == 0);
    check("post_rst_count", 16'(got.size()), 16'h1);
    if (got.size() >= 1) check("post_rst_n0", 16'(got[0]), 16'h0);

    do_rst();
    bus.byte_ready = 1'b0;
    pcm = 16'sh7FF0;
    for (int t = 0; t < 48; t++) tick(t % 2 == 0);
    check("hold_byte", 16'(bus.byte_data), 16'h77);
    check("hold_bv", 16'(bus.byte_valid), 16'h1);
    check("hold_ovf", 16'(ovf), 16'h1);
    do_clr();
    check("clr_ovf", 16'(ovf), 16'h0);
    check("clr_bv", 16'(bus.byte_valid), 16'h1);
    check("clr_byte", 16'(bus.byte_data), 16'h77);
    bus.byte_ready = 1'b1;
    clk_step(1'b0, 1'b0);
    check("accept_bv", 16'(bus.byte_valid), 16'h0);

    do_rst();
    for (int i = 0; i < 200; i++) begin
      pcm = ((i / 3) % 2 == 1) ? 16'sh8000 : 16'sh7FFF;
      tick(1'b1);
      tick(1'b0);
    end

    do_clr();
    got.delete();
    for (int i = 0; i < 60; i++) begin
      pcm = 16'(i * 2741 - 20000);
      tick(1'b1);
    end
    for (int i = 0; i < 6; i++) tick(1'b0);
    check("fast_ovf", 16'(ovf), 16'h1);
    check("fast_count", 16'(got.size()), 16'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
